// File: rtl/bcd_disp_pkg.sv
// Shared seven-segment definitions for the BCD display path.
// Patterns are active-high with bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'(1 << SEG_G);
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-high output.
// Non-decimal codes 10-15 show a single dash.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Multiplexed seven-segment scanner: per-frame snapshot of packed BCD,
// leading-zero blanking, polarity applied only at the output registers.
module bcd_seg_scanner
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int   PW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] snap_bcd;
    logic [DIGITS-1:0]   snap_dp;

    logic                frame_start;
    logic [4*DIGITS-1:0] cur_bcd;
    logic [DIGITS-1:0]   cur_dp;
    logic [3:0]          cur_digit;
    logic [6:0]          dec_seg;
    logic [DIGITS-1:0]   upper_zero;
    logic                blank;
    logic [DIGITS-1:0]   an_on;
    logic [6:0]          seg_on;
    logic                dp_on;

    assign frame_start = rst && en && (presc == '0) && (idx == '0);
    assign frame_tick  = frame_start;

    // Forward the live inputs on the load cycle so digit 0 of the new frame
    // reaches the outputs one edge after its sample point.
    assign cur_bcd   = frame_start ? bcd_in : snap_bcd;
    assign cur_dp    = frame_start ? dp_in  : snap_dp;
    assign cur_digit = cur_bcd[4*idx +: 4];

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // upper_zero[i]: digits i..DIGITS-1 are all zero; digit 0 never qualifies.
    always_comb begin
        upper_zero = '0;
        for (int unsigned i = 1; i < DIGITS; i++)
            upper_zero[i] = ((cur_bcd >> (4*i)) == '0);
    end

    assign blank  = blank_lz && upper_zero[idx];
    assign an_on  = DIGITS'(1) << idx;
    assign seg_on = blank ? SEG_OFF : dec_seg;
    assign dp_on  = cur_dp[idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc    <= '0;
            idx      <= '0;
            snap_bcd <= '0;
            snap_dp  <= '0;
            an       <= {DIGITS{POL}};
            seg      <= {7{POL}};
            dp       <= POL;
        end else if (en) begin
            if (frame_start) begin
                snap_bcd <= bcd_in;
                snap_dp  <= dp_in;
            end
            if (presc == PW'(REFRESH_DIV - 1)) begin
                presc <= '0;
                idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            an  <= an_on  ^ {DIGITS{POL}};
            seg <= seg_on ^ {7{POL}};
            dp  <= dp_on  ^ POL;
        end else begin
            an  <= {DIGITS{POL}};
            seg <= {7{POL}};
            dp  <= POL;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1).
module tb_bcd_seg_scanner;

    localparam int D     = 4;
    localparam int RD    = 4;
    localparam int FRAME = D * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    bcd_seg_scanner #(.DIGITS(D), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: n = enabled cycles into the current frame.
    int          n = 0;
    logic [15:0] msnap = '0;
    logic [3:0]  mdp = '0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;
    logic [6:0]  segtab [16];

    function automatic logic exp_tick();
        return rst && en && (n == 0);
    endfunction

    task automatic tick();
        int slot;
        int digit;
        bit blnk;
        @(posedge clk);
        if (!rst) begin
            n = 0; msnap = '0; mdp = '0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else if (en) begin
            if (n == 0) begin
                msnap = bcd_in;
                mdp = dp_in;
            end
            slot  = n / RD;
            digit = int'((msnap >> (4*slot)) & 16'hF);
            blnk  = blank_lz && (slot > 0) && ((msnap >> (4*slot)) == 16'h0);
            exp_an  = ~(4'b0001 << slot);
            exp_seg = blnk ? 7'h7F : ~segtab[digit];
            exp_dp  = ~mdp[slot];
            n = (n + 1) % FRAME;
        end else begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end
        #1;
    endtask

    task automatic align();
        for (int k = 0; k < FRAME && n != 0; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0;
        repeat (3) tick();
        checks++;
        if ({an, seg, dp, frame_tick} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset: an=%b seg=%h dp=%b tick=%b want an=1111 seg=7f dp=1 tick=0",
                     an, seg, dp, frame_tick);
        end
    endtask

    task automatic test_scan();
        rst = 1'b1; en = 1'b1; blank_lz = 1'b0; bcd_in = 16'h1234; dp_in = 4'b0100;
        #1;
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL first_tick: tick=%b want 1", frame_tick);
        end
        for (int k = 0; k < FRAME; k++) begin
            tick();
            checks++;
            if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_tick()}) begin
                failures++;
                $display("FAIL scan k=%0d: an=%b seg=%h dp=%b tick=%b want an=%b seg=%h dp=%b tick=%b",
                         k, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_tick());
            end
            if (k == 0) begin
                checks++;
                if ({an, seg} !== {4'b1110, 7'h19}) begin
                    failures++;
                    $display("FAIL digit0_four: an=%b seg=%h want an=1110 seg=19", an, seg);
                end
            end
        end
    endtask

    task automatic test_lz(input logic [15:0] val, input logic [27:0] want);
        logic [6:0] w;
        blank_lz = 1'b1; bcd_in = val; dp_in = 4'b0000;
        align();
        for (int k = 0; k < FRAME; k++) begin
            tick();
            checks++;
            if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_tick()}) begin
                failures++;
                $display("FAIL lz %h k=%0d: an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         val, k, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (k % RD == 0) begin
                w = want[7*(k/RD) +: 7];
                checks++;
                if ({an, seg} !== {~(4'b0001 << (k/RD)), w}) begin
                    failures++;
                    $display("FAIL lz_slot %h slot=%0d: an=%b seg=%h want seg=%h", val, k/RD, an, seg, w);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        blank_lz = 1'b0; bcd_in = 16'h1234; dp_in = 4'b0001;
        align();
        for (int k = 0; k < FRAME + 1; k++) begin
            if (k == 6) bcd_in = 16'h5678;
            tick();
            checks++;
            if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_tick()}) begin
                failures++;
                $display("FAIL b2b k=%0d: an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         k, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (k == 8 || k == 12 || k == 16) begin
                checks++;
                if (seg !== (k == 8 ? 7'h24 : (k == 12 ? 7'h79 : 7'h00))) begin
                    failures++;
                    $display("FAIL b2b_hold k=%0d: seg=%h", k, seg);
                end
            end
        end
    endtask

    task automatic test_en_drop();
        int lit = 0;
        bcd_in = 16'h1234; dp_in = 4'b0000;
        align();
        repeat (9) tick();
        if (an === 4'b1011) lit++;
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({an, seg, dp, frame_tick} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL en_off k=%0d: an=%b seg=%h dp=%b tick=%b want dark", k, an, seg, dp, frame_tick);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (an === 4'b1011) lit++;
            checks++;
            if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_tick()}) begin
                failures++;
                $display("FAIL en_resume k=%0d: an=%b seg=%h want an=%b seg=%h", k, an, seg, exp_an, exp_seg);
            end
        end
        checks++;
        if (lit != RD) begin
            failures++;
            $display("FAIL slot2_len: lit=%0d want %0d", lit, RD);
        end
    endtask

    task automatic test_reset_mid();
        align();
        repeat (6) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({an, seg, dp, frame_tick} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid: an=%b seg=%h dp=%b tick=%b want dark tick=0", an, seg, dp, frame_tick);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL restart_tick: tick=%b want 1", frame_tick);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bcd_in = 16'($urandom);
            if ($urandom_range(0, 2) == 0) bcd_in = bcd_in & 16'h00FF;
            if ($urandom_range(0, 3) == 0) bcd_in = bcd_in & 16'h000F;
            dp_in = 4'($urandom);
            if (k % 25 == 0) blank_lz = 1'($urandom);
            en  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 99) != 0);
            tick();
            checks++;
            if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_tick()}) begin
                failures++;
                $display("FAIL random k=%0d: an=%b seg=%h dp=%b tick=%b want an=%b seg=%h dp=%b tick=%b",
                         k, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_tick());
            end
        end
        rst = 1'b1; en = 1'b1;
    endtask

    initial begin
        segtab[0] = 7'h3F; segtab[1] = 7'h06; segtab[2] = 7'h5B; segtab[3] = 7'h4F;
        segtab[4] = 7'h66; segtab[5] = 7'h6D; segtab[6] = 7'h7D; segtab[7] = 7'h07;
        segtab[8] = 7'h7F; segtab[9] = 7'h6F;
        for (int i = 10; i < 16; i++) segtab[i] = 7'h40;

        test_reset();
        test_scan();
        // slot order packed as {slot3, slot2, slot1, slot0}, active-low patterns
        test_lz(16'h0070, {7'h7F, 7'h7F, 7'h78, 7'h40});
        test_lz(16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        test_lz(16'h00A0, {7'h7F, 7'h7F, 7'h3F, 7'h40});
        test_back_to_back();
        test_en_drop();
        test_reset_mid();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scanner.md
# bcd_seg_scanner

Multiplexed seven-segment display driver that consumes packed BCD digits from the counter stages (e.g. a chain of BCD down-counters) and time-multiplexes them onto a common segment bus with one anode enable per digit. It sits directly downstream of the counters, snapshots their outputs once per refresh frame for tear-free display, and provides optional leading-zero blanking and invalid-code flagging.

## Interface
- DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 50000, clock cycles per digit slot (≥2)
- ACTIVE_LOW, 1, 1 = seg/dp/an drive low to light; 0 = drive high to light
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous and active-low, sampled on rising clk
- en  input  1  scan enable; 0 blanks the display and freezes scan state
- bcd_in  input  4*DIGITS  packed BCD; bcd_in[3:0] = digit 0 (least significant)
- dp_in  input  DIGITS  decimal-point request per digit
- blank_lz  input  1  1 = suppress leading zeros
- seg  output  7  segments {g,f,e,d,c,b,a}, registered
- dp  output  1  decimal point, registered
- an  output  DIGITS  one-hot digit enable, registered
- frame_tick  output  1  one-cycle pulse at each frame start

## Operation
- Prescaler counts 0..REFRESH_DIV-1 while en=1; at terminal count it wraps to 0 and the digit index advances 0,1,…,DIGITS-1, wrapping to 0.
- Frame start: cycle with en=1, prescaler=0, index=0. In that cycle bcd_in and dp_in load into the snapshot registers and frame_tick=1.
- Every en=1 cycle the output registers load decode(index, snapshot): an lights only bit[index]; seg = bcd_to_seg7(snapshot digit[index]); dp = snapshot dp[index].
- Decode: 0-9 standard patterns; codes 10-15 light g only ("-").
- Leading-zero blanking (blank_lz=1): digit i>0 is blanked (all segments off, an still lit) when snapshot digits i..DIGITS-1 are all 0. Digit 0 is never blanked; invalid codes count as nonzero. dp still follows dp_in.
- en=0: prescaler, index and snapshot hold; output registers load all-off (an, seg, dp dark); frame_tick=0. Re-enable resumes the same slot with its remaining count.
- Polarity: ACTIVE_LOW inverts seg, dp and an at the output registers only.

## Timing
- Reset (rst=0 at a rising edge): prescaler=0, index=0, snapshot=0, an/seg/dp all dark, frame_tick=0. Reset mid-frame takes effect on the next edge and overrides en.
- First en=1 cycle after reset is a frame start.
- Latency: bcd_in sampled at frame-start cycle T is visible on seg/an at T+1 (registered output of the digit-0 decode is updated at the T+1 edge from the new snapshot; decode uses the snapshot mux-forward on the load cycle).
- bcd_in changes between frame starts have no visible effect until the next frame start.
- Each digit is lit for exactly REFRESH_DIV cycles; frame period DIGITS*REFRESH_DIV cycles.
- frame_tick is a decode of registered state, high for exactly one cycle per frame.

## Structure
- Package bcd_disp_pkg: 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (active-high form), segment bit-order constants.
- Sub-module bcd_to_seg7: combinational 4-bit BCD → 7-bit active-high pattern, dash for 10-15.
- Top holds prescaler, index, snapshot, LZ-blank logic, polarity inversion, output registers.

## Test plan
Bench parameters: DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
- Hold rst=0 three cycles -> an=4'b1111, seg=7'h7F, dp=1, frame_tick=0.
- Release rst, en=1, bcd_in=16'h1234, blank_lz=0 -> frame_tick at first cycle; an cycles 1110,1101,1011,0111 for 4 cycles each; digit 0 seg=7'h19 ("4").
- blank_lz=1, bcd_in=16'h0070 -> digits 3,2 seg=7'h7F with an lit; digit 1 "7" (7'h78); digit 0 "0" (7'h40). bcd_in=16'h0000 -> only digit 0 shows 7'h40.
- bcd_in=16'h00A0 -> digit 1 seg=7'h3F (dash), digit 2,3 blanked with blank_lz=1.
- Change bcd_in from 16'h1234 to 16'h5678 during slot 1 -> remaining slots still show 2,1; new value appears from the cycle after the next frame_tick.
- Drop en for 3 cycles mid-slot 2 -> an=1111 next cycle; on re-enable slot 2 resumes and lasts 4 total lit cycles; rst=0 mid-frame -> reset state next edge.
